// File: rtl/control_sequencer.sv
// Hardwired control unit for the Mini SRC datapath: fetch (T0-T2), decode, and execute
// steps (T3-T6) for register ALU, MUL/DIV, NEG/NOT, NOP and HALT, plus a retired-instruction count.
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             mem_rdy_i,
  input  logic [31:0]      ir_i,
  output logic             pc_out_o,
  output logic             zhigh_out_o,
  output logic             zlow_out_o,
  output logic             mdr_out_o,
  output logic             mar_in_o,
  output logic             z_in_o,
  output logic             pc_in_o,
  output logic             mdr_in_o,
  output logic             ir_in_o,
  output logic             y_in_o,
  output logic             lo_in_o,
  output logic             hi_in_o,
  output logic             inc_pc_o,
  output logic             read_o,
  output logic             gra_o,
  output logic             grb_o,
  output logic             grc_o,
  output logic             rin_o,
  output logic             rout_o,
  output logic [12:0]      alu_sel_o,
  output logic             halted_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instr_count_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_BIN, C_MULDIV, C_UNARY, C_NOP, C_HALT, C_ILL
  } cls_t;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [4:0]  op;
  cls_t        cls;
  logic [12:0] alu_onehot;
  logic        alu_en;
  logic        retire;
  state_t      end_state;
  logic        unused_ir;

  assign op        = ir_i[31:27];
  assign unused_ir = ^ir_i[26:0];
  assign end_state = run_i ? S_T0 : S_IDLE;

  always_comb begin
    cls        = C_ILL;
    alu_onehot = '0;
    unique case (op)
      5'd5:  begin cls = C_BIN;    alu_onehot = 13'h0001; end
      5'd6:  begin cls = C_BIN;    alu_onehot = 13'h0002; end
      5'd3:  begin cls = C_BIN;    alu_onehot = 13'h0004; end
      5'd4:  begin cls = C_BIN;    alu_onehot = 13'h0008; end
      5'd15: begin cls = C_MULDIV; alu_onehot = 13'h0010; end
      5'd16: begin cls = C_MULDIV; alu_onehot = 13'h0020; end
      5'd9:  begin cls = C_BIN;    alu_onehot = 13'h0040; end
      5'd10: begin cls = C_BIN;    alu_onehot = 13'h0080; end
      5'd11: begin cls = C_BIN;    alu_onehot = 13'h0100; end
      5'd7:  begin cls = C_BIN;    alu_onehot = 13'h0200; end
      5'd8:  begin cls = C_BIN;    alu_onehot = 13'h0400; end
      5'd17: begin cls = C_UNARY;  alu_onehot = 13'h0800; end
      5'd18: begin cls = C_UNARY;  alu_onehot = 13'h1000; end
      5'd26: cls = C_NOP;
      5'd27: cls = C_HALT;
      default: cls = C_ILL;
    endcase
  end

  // Any execute state reached with an unexpected class (IR changed underneath) simply retires.
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    alu_en      = 1'b0;
    pc_out_o    = 1'b0;
    zhigh_out_o = 1'b0;
    zlow_out_o  = 1'b0;
    mdr_out_o   = 1'b0;
    mar_in_o    = 1'b0;
    z_in_o      = 1'b0;
    pc_in_o     = 1'b0;
    mdr_in_o    = 1'b0;
    ir_in_o     = 1'b0;
    y_in_o      = 1'b0;
    lo_in_o     = 1'b0;
    hi_in_o     = 1'b0;
    inc_pc_o    = 1'b0;
    read_o      = 1'b0;
    gra_o       = 1'b0;
    grb_o       = 1'b0;
    grc_o       = 1'b0;
    rin_o       = 1'b0;
    rout_o      = 1'b0;
    halted_o    = 1'b0;
    unique case (state_q)
      S_IDLE: if (run_i) state_d = S_T0;
      S_T0: begin
        pc_out_o = 1'b1; mar_in_o = 1'b1; inc_pc_o = 1'b1; z_in_o = 1'b1;
        state_d  = S_T1;
      end
      S_T1: begin
        // Held while memory is busy; reloading PC with the same value is harmless.
        zlow_out_o = 1'b1; pc_in_o = 1'b1; read_o = 1'b1; mdr_in_o = 1'b1;
        if (mem_rdy_i) state_d = S_T2;
      end
      S_T2: begin
        mdr_out_o = 1'b1; ir_in_o = 1'b1;
        if (cls == C_NOP || cls == C_ILL) begin
          retire  = 1'b1;
          state_d = end_state;
        end else begin
          state_d = S_T3;
        end
      end
      S_T3: begin
        unique case (cls)
          C_BIN:    begin grb_o = 1'b1; rout_o = 1'b1; y_in_o = 1'b1; state_d = S_T4; end
          C_MULDIV: begin gra_o = 1'b1; rout_o = 1'b1; y_in_o = 1'b1; state_d = S_T4; end
          C_UNARY: begin
            grb_o = 1'b1; rout_o = 1'b1; alu_en = 1'b1; z_in_o = 1'b1;
            state_d = S_T4;
          end
          C_HALT:  begin retire = 1'b1; state_d = S_HALT; end
          default: begin retire = 1'b1; state_d = end_state; end
        endcase
      end
      S_T4: begin
        unique case (cls)
          C_BIN: begin
            grc_o = 1'b1; rout_o = 1'b1; alu_en = 1'b1; z_in_o = 1'b1;
            state_d = S_T5;
          end
          C_MULDIV: begin
            grb_o = 1'b1; rout_o = 1'b1; alu_en = 1'b1; z_in_o = 1'b1;
            state_d = S_T5;
          end
          C_UNARY: begin
            zlow_out_o = 1'b1; gra_o = 1'b1; rin_o = 1'b1;
            retire = 1'b1; state_d = end_state;
          end
          default: begin retire = 1'b1; state_d = end_state; end
        endcase
      end
      S_T5: begin
        unique case (cls)
          C_BIN: begin
            zlow_out_o = 1'b1; gra_o = 1'b1; rin_o = 1'b1;
            retire = 1'b1; state_d = end_state;
          end
          C_MULDIV: begin zlow_out_o = 1'b1; lo_in_o = 1'b1; state_d = S_T6; end
          default:  begin retire = 1'b1; state_d = end_state; end
        endcase
      end
      S_T6: begin
        zhigh_out_o = 1'b1; hi_in_o = 1'b1;
        retire = 1'b1; state_d = end_state;
      end
      S_HALT: halted_o = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign alu_sel_o = alu_en ? alu_onehot : 13'h0000;
  assign illegal_d = illegal_q | (state_q == S_T2 && cls == C_ILL);
  assign count_d   = count_q + CNT_W'(retire);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign illegal_o     = illegal_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes per-cycle expected outputs from an
// instruction-level step table; a negedge monitor pops and compares against the DUT.
module tb_control_sequencer;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_ni, run_i, mem_rdy_i;
  logic [31:0] ir_i;
  logic pc_out_o, zhigh_out_o, zlow_out_o, mdr_out_o, mar_in_o, z_in_o, pc_in_o, mdr_in_o;
  logic ir_in_o, y_in_o, lo_in_o, hi_in_o, inc_pc_o, read_o, gra_o, grb_o, grc_o, rin_o, rout_o;
  logic [12:0] alu_sel_o;
  logic halted_o, illegal_o;
  logic [CNT_W-1:0] instr_count_o;

  control_sequencer #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .run_i(run_i), .mem_rdy_i(mem_rdy_i), .ir_i(ir_i),
    .pc_out_o(pc_out_o), .zhigh_out_o(zhigh_out_o), .zlow_out_o(zlow_out_o),
    .mdr_out_o(mdr_out_o), .mar_in_o(mar_in_o), .z_in_o(z_in_o), .pc_in_o(pc_in_o),
    .mdr_in_o(mdr_in_o), .ir_in_o(ir_in_o), .y_in_o(y_in_o), .lo_in_o(lo_in_o),
    .hi_in_o(hi_in_o), .inc_pc_o(inc_pc_o), .read_o(read_o), .gra_o(gra_o), .grb_o(grb_o),
    .grc_o(grc_o), .rin_o(rin_o), .rout_o(rout_o), .alu_sel_o(alu_sel_o),
    .halted_o(halted_o), .illegal_o(illegal_o), .instr_count_o(instr_count_o)
  );

  always #5 clk = ~clk;

  localparam logic [18:0] PCOUT = 19'd1 << 0,  ZHIGH = 19'd1 << 1,  ZLOW  = 19'd1 << 2;
  localparam logic [18:0] MDROUT = 19'd1 << 3, MARIN = 19'd1 << 4,  ZIN   = 19'd1 << 5;
  localparam logic [18:0] PCIN  = 19'd1 << 6,  MDRIN = 19'd1 << 7,  IRIN  = 19'd1 << 8;
  localparam logic [18:0] YIN   = 19'd1 << 9,  LOIN  = 19'd1 << 10, HIIN  = 19'd1 << 11;
  localparam logic [18:0] INCPC = 19'd1 << 12, READ  = 19'd1 << 13, GRA   = 19'd1 << 14;
  localparam logic [18:0] GRB   = 19'd1 << 15, GRC   = 19'd1 << 16, RIN   = 19'd1 << 17;
  localparam logic [18:0] ROUT  = 19'd1 << 18;
  localparam logic [18:0] T0_M = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [18:0] T1_M = ZLOW | PCIN | READ | MDRIN;
  localparam logic [18:0] T2_M = MDROUT | IRIN;

  typedef logic [49:0] vec_t;  // {count, illegal, halted, alusel, strobes}
  vec_t exp_q[$];
  vec_t mon_exp, mon_act;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  logic [CNT_W-1:0] m_count;
  logic m_illegal, m_halted, m_idle;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {instr_count_o, illegal_o, halted_o, alu_sel_o,
                 rout_o, rin_o, grc_o, grb_o, gra_o, read_o, inc_pc_o, hi_in_o, lo_in_o,
                 y_in_o, ir_in_o, mdr_in_o, pc_in_o, z_in_o, mar_in_o, mdr_out_o,
                 zlow_out_o, zhigh_out_o, pc_out_o};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL outputs cyc=%0d act=%h exp=%h", cyc, mon_act, mon_exp);
      end
    end
  end

  function automatic logic rbit();
    return ($urandom() & 32'd1) != 0;
  endfunction

  // 0 binary ALU, 1 MUL/DIV, 2 NEG/NOT, 3 NOP, 4 HALT, 5 undefined
  function automatic int cls_of(input logic [4:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: return 0;
      5'd15, 5'd16: return 1;
      5'd17, 5'd18: return 2;
      5'd26: return 3;
      5'd27: return 4;
      default: return 5;
    endcase
  endfunction

  // AluSel bit i corresponds to ops[i]: AND OR ADD SUB MUL DIV SHR SHRA SHL ROR ROL NEG NOT
  function automatic logic [12:0] alu_of(input logic [4:0] op);
    logic [4:0] ops [13];
    ops = '{5'd5, 5'd6, 5'd3, 5'd4, 5'd15, 5'd16, 5'd9, 5'd10, 5'd11, 5'd7, 5'd8, 5'd17, 5'd18};
    for (int i = 0; i < 13; i++)
      if (ops[i] == op) return 13'd1 << i;
    return 13'd0;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom();
    return {op, r[26:0]};
  endfunction

  task automatic step(input logic rstn, input logic run, input logic rdy, input logic [31:0] ir,
                      input logic [18:0] strobes, input logic [12:0] alu);
    @(posedge clk);
    #1;
    rst_ni    = rstn;
    run_i     = run;
    mem_rdy_i = rdy;
    ir_i      = ir;
    exp_q.push_back({m_count, m_illegal, m_halted, alu, strobes});
  endtask

  task automatic leave_idle(input logic [31:0] ir);
    if (m_idle) begin
      step(1'b1, 1'b1, rbit(), ir, 19'd0, 13'd0);
      m_idle = 1'b0;
    end
  endtask

  task automatic do_instr(input logic [31:0] ir, input int stalls, input logic run_end);
    int c;
    logic [12:0] a;
    c = cls_of(ir[31:27]);
    a = alu_of(ir[31:27]);
    leave_idle(ir);
    step(1'b1, rbit(), rbit(), ir, T0_M, 13'd0);
    repeat (stalls) step(1'b1, rbit(), 1'b0, ir, T1_M, 13'd0);
    step(1'b1, rbit(), 1'b1, ir, T1_M, 13'd0);
    if (c == 3 || c == 5) begin
      step(1'b1, run_end, rbit(), ir, T2_M, 13'd0);
      if (c == 5) m_illegal = 1'b1;
    end else begin
      step(1'b1, rbit(), rbit(), ir, T2_M, 13'd0);
      case (c)
        0: begin
          step(1'b1, rbit(), rbit(), ir, GRB | ROUT | YIN, 13'd0);
          step(1'b1, rbit(), rbit(), ir, GRC | ROUT | ZIN, a);
          step(1'b1, run_end, rbit(), ir, ZLOW | GRA | RIN, 13'd0);
        end
        1: begin
          step(1'b1, rbit(), rbit(), ir, GRA | ROUT | YIN, 13'd0);
          step(1'b1, rbit(), rbit(), ir, GRB | ROUT | ZIN, a);
          step(1'b1, rbit(), rbit(), ir, ZLOW | LOIN, 13'd0);
          step(1'b1, run_end, rbit(), ir, ZHIGH | HIIN, 13'd0);
        end
        2: begin
          step(1'b1, rbit(), rbit(), ir, GRB | ROUT | ZIN, a);
          step(1'b1, run_end, rbit(), ir, ZLOW | GRA | RIN, 13'd0);
        end
        default: begin
          step(1'b1, rbit(), rbit(), ir, 19'd0, 13'd0);
          m_halted = 1'b1;
        end
      endcase
    end
    m_count = m_count + 1'b1;
    if (c != 4) m_idle = !run_end;
    $display("instr op=%0d ir=%h stalls=%0d run_end=%0d count=%0d", ir[31:27], ir, stalls,
             run_end, m_count);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step(1'b1, 1'b0, rbit(), 32'h0, 19'd0, 13'd0);
  endtask

  task automatic apply_reset(input int n);
    m_count   = '0;
    m_illegal = 1'b0;
    m_halted  = 1'b0;
    repeat (n) step(1'b0, 1'b0, rbit(), 32'h0, 19'd0, 13'd0);
    step(1'b1, 1'b0, rbit(), 32'h0, 19'd0, 13'd0);
    m_idle = 1'b1;
  endtask

  initial begin
    logic [4:0] op;
    logic [31:0] ir;
    int guard;
    rst_ni    = 1'b0;
    run_i     = 1'b0;
    mem_rdy_i = 1'b0;
    ir_i      = 32'h0;
    m_count   = '0;
    m_illegal = 1'b0;
    m_halted  = 1'b0;
    m_idle    = 1'b1;
    apply_reset(2);
    idle_cycles(2);

    do_instr(32'h2A2B8000, 0, 1'b1);          // AND ra4 rb5 rc7
    do_instr(mk_ir(5'd3), 4, 1'b1);           // ADD with a 4-cycle memory stall
    do_instr(mk_ir(5'd15), 0, 1'b1);          // MUL
    do_instr(32'h8A800000, 0, 1'b0);          // NEG, then drop Run
    idle_cycles(3);
    do_instr(mk_ir(5'd16), 1, 1'b1);          // DIV
    do_instr(mk_ir(5'd18), 0, 1'b1);          // NOT
    do_instr(mk_ir(5'd26), 2, 1'b1);          // NOP

    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      do_instr(mk_ir(op), $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
      if (m_idle) idle_cycles($urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of T4 of a SUB
    ir = mk_ir(5'd4);
    leave_idle(ir);
    step(1'b1, 1'b1, rbit(), ir, T0_M, 13'd0);
    step(1'b1, 1'b1, 1'b1, ir, T1_M, 13'd0);
    step(1'b1, 1'b1, rbit(), ir, T2_M, 13'd0);
    step(1'b1, 1'b1, rbit(), ir, GRB | ROUT | YIN, 13'd0);
    apply_reset(2);
    idle_cycles(1);

    // Undefined opcode, then HALT; Run stays high while halted
    do_instr(mk_ir(5'd31), 0, 1'b1);
    do_instr(mk_ir(5'd27), 0, 1'b1);
    repeat (20) step(1'b1, 1'b1, rbit(), 32'hD8000000, 19'd0, 13'd0);

    apply_reset(1);
    do_instr(mk_ir(5'd26), 0, 1'b0);
    idle_cycles(2);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      $display("FAIL drain pending=%0d required=0", exp_q.size());
      $fatal(1, "scoreboard did not drain");
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
